// File: rtl/picosoc_a2_mailbox_pkg.sv
// Shared register map, field positions and FIFO entry type for the
// Apple II -> PicoSoC command/data mailbox.
package a2_mailbox_pkg;

    localparam logic [1:0] REG_STATUS   = 2'd0;
    localparam logic [1:0] REG_POP      = 2'd1;
    localparam logic [1:0] REG_CONTROL  = 2'd2;
    localparam logic [1:0] REG_LAST_CMD = 2'd3;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_COUNT_LSB = 8;

    localparam int CTRL_CLR_OVF = 0;
    localparam int CTRL_FLUSH   = 1;

    typedef struct packed {
        logic       is_cmd;
        logic [7:0] data;
    } mbox_entry_t;

    function automatic logic [31:0] status_word(input logic [7:0] count,
                                                input logic overflow,
                                                input logic full,
                                                input logic empty);
        logic [31:0] w;
        w = '0;
        w[STAT_COUNT_LSB +: 8] = count;
        w[STAT_OVERFLOW]       = overflow;
        w[STAT_FULL]           = full;
        w[STAT_EMPTY]          = empty;
        return w;
    endfunction

endpackage

// File: rtl/picosoc_a2_mailbox_if.sv
// Apple II bus write-capture signals as seen by slot peripherals.
interface a2bus_if;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw_n;
    logic        data_in_strobe;

    modport master (output addr, data, rw_n, data_in_strobe);
    modport slave  (input  addr, data, rw_n, data_in_strobe);
endinterface

// File: rtl/picosoc_a2_mailbox_fifo.sv
// Synchronous FIFO with flush; a pop makes room for a push in the same cycle.
module a2_byte_fifo
    import a2_mailbox_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = mbox_entry_t,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        din,
    output entry_t        dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_pop;
    logic           do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only entries behind valid pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/picosoc_a2_mailbox.sv
// Captures Apple II slot writes into a FIFO and exposes it to PicoSoC firmware
// over iomem, with a level interrupt while bytes are pending.
module picosoc_a2_mailbox
    import a2_mailbox_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [15:0] CMD_ADDR  = 16'hC7FF,
    parameter logic [15:0] DATA_ADDR = 16'hC7FE
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        iomem_ready,
    a2bus_if.slave      a2bus,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);

    logic          accept;
    logic          is_write;
    logic [1:0]    reg_sel;
    logic          pop_req;
    logic          ctrl_wr;
    logic          flush;
    logic          clr_ovf;
    logic          hit_cmd;
    logic          hit_data;
    logic          push_req;
    logic          dropped;
    logic          overflow;
    logic [7:0]    last_cmd;
    logic [31:0]   rd_word;
    mbox_entry_t   din;
    mbox_entry_t   dout;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          unused_bits;

    assign unused_bits = ^{iomem_addr[31:4], iomem_addr[1:0], iomem_wdata[31:2]};

    // Re-acceptance is blocked during the ready cycle so a held valid pops once.
    assign accept   = iomem_valid && !iomem_ready;
    assign is_write = |iomem_wstrb;
    assign reg_sel  = iomem_addr[3:2];
    assign pop_req  = accept && !is_write && (reg_sel == REG_POP);
    assign ctrl_wr  = accept && is_write && (reg_sel == REG_CONTROL);
    assign flush    = ctrl_wr && iomem_wdata[CTRL_FLUSH];
    assign clr_ovf  = ctrl_wr && iomem_wdata[CTRL_CLR_OVF];

    assign hit_cmd  = a2bus.data_in_strobe && !a2bus.rw_n && (a2bus.addr == CMD_ADDR);
    assign hit_data = a2bus.data_in_strobe && !a2bus.rw_n && (a2bus.addr == DATA_ADDR);
    assign push_req = hit_cmd || hit_data;
    assign din      = '{is_cmd: hit_cmd, data: a2bus.data};
    assign dropped  = push_req && full && !(pop_req && !empty) && !flush;

    assign irq = !empty;

    a2_byte_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (mbox_entry_t)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_req),
        .pop    (pop_req),
        .flush  (flush),
        .din    (din),
        .dout   (dout),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_STATUS:   rd_word = status_word(8'(count), overflow, full, empty);
            REG_POP:      if (!empty) rd_word = {22'b0, 1'b1, dout};
            REG_LAST_CMD: rd_word = {24'b0, last_cmd};
            default:      rd_word = '0;
        endcase
    end

    // A drop in the same cycle as a clear leaves overflow set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
            last_cmd <= '0;
        end else begin
            if (dropped)      overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
            if (hit_cmd)      last_cmd <= a2bus.data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
        end else begin
            iomem_ready <= accept;
            iomem_rdata <= (accept && !is_write) ? rd_word : '0;
        end
    end

endmodule

// File: tb/tb_picosoc_a2_mailbox.sv
// Directed bench with an expected-pop scoreboard for the A2 mailbox.
module tb_picosoc_a2_mailbox;

    logic        clk = 1'b0;
    logic        resetn;
    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        iomem_ready;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    a2bus_if a2 ();

    picosoc_a2_mailbox #(
        .DEPTH     (16),
        .CMD_ADDR  (16'hC7FF),
        .DATA_ADDR (16'hC7FE)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .iomem_ready (iomem_ready),
        .a2bus       (a2),
        .irq         (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output logic [31:0] rd);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!iomem_ready && n < 8);
        if (!iomem_ready) check("ready_timeout", {31'b0, iomem_ready}, 32'h1);
        rd = iomem_rdata;
    endtask

    task automatic bus_xfer(input logic [1:0] r, input logic wr, input logic [31:0] wd,
                            output logic [31:0] rd);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = {28'b0, r, 2'b00};
        iomem_wstrb = wr ? 4'hF : 4'h0;
        iomem_wdata = wd;
        wait_ready(rd);
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    task automatic rd_chk(input logic [1:0] r, input string tag, input logic [31:0] exp);
        logic [31:0] v;
        bus_xfer(r, 1'b0, 32'h0, v);
        check(tag, v, exp);
    endtask

    task automatic pop_chk(input string tag);
        logic [31:0] v;
        logic [31:0] exp;
        exp = (sb.size() > 0) ? sb.pop_front() : 32'h0;
        bus_xfer(2'd1, 1'b0, 32'h0, v);
        check(tag, v, exp);
    endtask

    task automatic a2_drive(input logic [15:0] a, input logic [7:0] d);
        a2.addr           = a;
        a2.data           = d;
        a2.rw_n           = 1'b0;
        a2.data_in_strobe = 1'b1;
    endtask

    task automatic a2_idle();
        a2.data_in_strobe = 1'b0;
        a2.rw_n           = 1'b1;
    endtask

    task automatic a2_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        a2_drive(a, d);
        @(negedge clk);
        a2_idle();
    endtask

    initial begin
        logic [31:0] v;
        int pulses;

        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;
        a2.addr     = 16'h0;
        a2.data     = 8'h0;
        a2_idle();
        #12;
        check("reset_irq",   {31'b0, irq}, 32'h0);
        check("reset_ready", {31'b0, iomem_ready}, 32'h0);
        check("reset_rdata", iomem_rdata, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Reset state and first pop
        rd_chk(2'd0, "status_after_reset", 32'h0000_0001);
        a2_write(16'hC7FF, 8'h42);
        sb.push_back(32'h342);
        check("irq_after_push", {31'b0, irq}, 32'h1);
        rd_chk(2'd0, "status_one", 32'h0000_0100);
        pop_chk("first_pop");
        check("irq_after_last_pop", {31'b0, irq}, 32'h0);

        // Ordering, LAST_CMD and empty pop
        a2_write(16'hC7FE, 8'h10); sb.push_back(32'h210);
        a2_write(16'hC7FE, 8'h11); sb.push_back(32'h211);
        a2_write(16'hC7FF, 8'h99); sb.push_back(32'h399);
        a2_write(16'hC000, 8'hEE);
        pop_chk("order_pop0");
        pop_chk("order_pop1");
        pop_chk("order_pop2");
        rd_chk(2'd3, "last_cmd", 32'h99);
        pop_chk("empty_pop");
        check("irq_empty", {31'b0, irq}, 32'h0);
        rd_chk(2'd2, "control_read", 32'h0);

        // Overflow: 17th byte dropped
        for (int i = 0; i < 17; i++) begin
            a2_write(16'hC7FE, 8'(8'h80 + i));
            if (i < 16) sb.push_back(32'h200 | (32'h80 + i));
        end
        rd_chk(2'd0, "status_overflow", 32'h0000_1006);
        bus_xfer(2'd2, 1'b1, 32'h1, v);
        rd_chk(2'd0, "status_ovf_cleared", 32'h0000_1002);
        for (int i = 0; i < 16; i++) pop_chk("overflow_pop");
        pop_chk("overflow_17th_absent");
        rd_chk(2'd0, "status_drained", 32'h0000_0001);

        // Simultaneous pop and push when full
        for (int i = 0; i < 16; i++) begin
            a2_write(16'hC7FE, 8'(8'h20 + i));
            sb.push_back(32'h200 | (32'h20 + i));
        end
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h4;
        iomem_wstrb = 4'h0;
        a2_drive(16'hC7FE, 8'h77);
        @(posedge clk);
        #1;
        check("simul_ready", {31'b0, iomem_ready}, 32'h1);
        check("simul_pop", iomem_rdata, sb.pop_front());
        sb.push_back(32'h277);
        @(negedge clk);
        iomem_valid = 1'b0;
        a2_idle();
        rd_chk(2'd0, "simul_status", 32'h0000_1002);
        for (int i = 0; i < 16; i++) pop_chk("simul_drain");

        // Held valid across the ready cycle pops once
        a2_write(16'hC7FE, 8'h31); sb.push_back(32'h231);
        a2_write(16'hC7FE, 8'h32); sb.push_back(32'h232);
        pulses = 0;
        v = 32'h0;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h4;
        iomem_wstrb = 4'h0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            if (iomem_ready) begin pulses++; v = iomem_rdata; end
        end
        @(negedge clk);
        iomem_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            if (iomem_ready) pulses++;
        end
        check("held_pulses", 32'(pulses), 32'h1);
        check("held_data", v, sb.pop_front());
        rd_chk(2'd0, "held_status", 32'h0000_0100);
        pop_chk("held_drain");

        // Flush coinciding with a push
        a2_write(16'hC7FE, 8'h01);
        a2_write(16'hC7FE, 8'h02);
        a2_write(16'hC7FF, 8'h03);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h8;
        iomem_wstrb = 4'hF;
        iomem_wdata = 32'h2;
        a2_drive(16'hC7FE, 8'h55);
        @(negedge clk);
        a2_idle();
        wait_ready(v);
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        sb.delete();
        check("flush_irq", {31'b0, irq}, 32'h0);
        rd_chk(2'd0, "flush_status", 32'h0000_0001);
        rd_chk(2'd3, "flush_last_cmd", 32'h03);

        // Reset with entries queued
        for (int i = 0; i < 5; i++) a2_write(16'hC7FE, 8'(i));
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midreset_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        rd_chk(2'd0, "post_reset_status", 32'h0000_0001);
        rd_chk(2'd3, "post_reset_last_cmd", 32'h0);
        pop_chk("post_reset_pop");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
